uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmit peripheral; the target that answers the processor core's load/store data-memory accesses in a reserved address window. Stores to the data register enqueue bytes into an internal FIFO. A serializer drains the FIFO onto a single TX line as 8N1 frames. Loads from the status register return FIFO and serializer state, so software can poll before writing.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, 2..256.
- `BASE_ADDR`, 32'h0000_F000: window base; word-aligned, 8 bytes wide.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: store strobe from the core (`is_store`).
- `mem_address` in 32: byte address of the current load/store.
- `w_data` in 32: store data; only [7:0] used.
- `r_data` out 32: load data, combinational from `mem_address`.
- `sel` out 1: high when `mem_address[31:3] == BASE_ADDR[31:3]`; the core muxes `r_data` over the RAM's data with it.
- `tx` out 1: serial line, idle high.

## Operation
- Register map (`mem_address[2]` selects the register; `[1:0]` are ignored):
  - +0 TXDATA. Write pushes `w_data[7:0]`. Read returns 0.
  - +4 STATUS. Read returns {zeros, count[8:0] at [12:4], overflow[3], empty[2], full[1], busy[0]}. Any write clears overflow.
- Push: occurs when `we && sel && !mem_address[2]`.
  - Accepted iff FIFO is not full, or a pop happens on the same edge.
  - Otherwise the byte is dropped and overflow sets (sticky).
- Count: simultaneous push and pop leaves count unchanged.
- Serializer states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START. Otherwise `tx`=1.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; a 3-bit index counts bits.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- busy = (state != IDLE).
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It resets to 0 on every state change.
- Reset values: `tx`=1, state IDLE, FIFO empty (count 0), overflow 0. The STATUS read value immediately after reset is 32'h4.
- Reset mid-frame: the frame is aborted, `tx` is 1 from the next edge, and FIFO contents are discarded.
- Loads have no side effects. Accesses outside the window: `sel`=0, `r_data`=0, no state change.

## Timing
- Push into an empty FIFO at edge N with the serializer idle:
  - pop and IDLE→START occur at edge N+1;
  - `tx` falls after edge N+1.
- No same-cycle bypass from `w_data` to `tx`.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- `r_data` and `sel` are combinational. STATUS reflects register state before the current edge.
- `tx` is driven from a flop; no combinational path from inputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP;
  - `tx` = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Undefined: DATA goes directly to STOP; the PARITY state and its logic are absent.

## Structure
- Package `uart_pkg`:
  - register offsets TXDATA_OFS=0, STATUS_OFS=4;
  - STATUS bit positions;
  - state enum `tx_state_t`.
- Sub-module `tx_fifo`: synchronous FIFO with push/pop/full/empty/count and a pop-frees-slot push rule. Read data is valid whenever not empty (first-word fall-through).
- Top level: address decode, STATUS mux, overflow flag, serializer FSM.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'hF000.
- Reset, then load 32'hF004 → `r_data`=32'h4, `sel`=1, `tx`=1.
- Store 32'hA5 to 32'hF000 → `tx` low one cycle after the push edge. Sample mid-bit: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total). STATUS returns to 32'h4.
- Five back-to-back stores 8'h01..8'h05 while idle:
  - first pops after one cycle;
  - remaining four fill the FIFO, no overflow;
  - a sixth store while full sets bit 3; a STATUS write clears it;
  - frames 01..05 are contiguous with no idle cycle between STOP and START.
- Store while full on the exact edge where STOP ends and pops → accepted, count unchanged, overflow stays 0.
- Assert `rst` mid-DATA with 2 bytes queued → `tx`=1 next cycle, STATUS=32'h4, no further frames.
- With `UART_TX_PARITY_EN`: store 8'h07 → parity bit 1 and frame length 44 cycles. Store 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, STATUS bit layout and serializer states
// UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte FIFO, first-word fall-through read data
// A push on a full FIFO is still accepted when a pop frees the slot on the same edge.
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] mem_address,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        sel,
    output logic        tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_sel;
    logic [2:0]    w_ofs;
    logic          w_push_req;
    logic          w_stat_wr;
    logic          w_pop;
    logic [7:0]    w_fifo_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_unused;

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [BW-1:0] r_baud;
    logic          w_baud_last;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_byte;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_overflow;

    assign w_sel      = (mem_address[31:3] == BASE_ADDR[31:3]);
    assign w_ofs      = {mem_address[2], 2'b00};
    assign w_push_req = we && w_sel && (w_ofs == TXDATA_OFS);
    assign w_stat_wr  = we && w_sel && (w_ofs == STATUS_OFS);
    assign w_unused   = ^{w_data[31:8], mem_address[1:0]};

    assign sel = w_sel;
    assign tx  = r_tx;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (w_data[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                                = '0;
        w_status[STAT_BUSY]                     = (r_state != ST_IDLE);
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_OVF]                      = r_overflow;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(w_count);
        r_data = (w_sel && (w_ofs == STATUS_OFS)) ? w_status : 32'h0;
    end

    // A dropped byte only counts as overflow when no pop frees a slot on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_stat_wr) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_last) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_baud_last) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM is going.
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = r_byte[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = ^r_byte;
`endif
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_byte    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            if (w_pop) r_byte <= w_fifo_data;
            if ((w_state_nxt != r_state) || w_baud_last || (r_state == ST_IDLE)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio against a frame-level model
module tb_uart_tx_mmio;

    localparam int          C     = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hF000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL   = NBITS * C;
    localparam int LOGN = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] w_data = 32'h0;
    logic [31:0] r_data;
    logic        sel;
    logic        tx;

    uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .mem_address (mem_address),
        .w_data      (w_data),
        .r_data      (r_data),
        .sel         (sel),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h0;
    bit         m_ovf = 1'b0;

    int          cyc_n = 0;
    logic        tx_log[LOGN];
    logic        busy_log[LOGN];
    logic        s_sel;
    logic [31:0] s_rd;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e_sel;
        logic [31:0] e_rd;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (NBITS == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic m_tx();
        return m_active ? frame_bit(m_byte, m_pos / C) : 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = 32'h0;
        s[12:4] = 9'(q.size());
        s[3]    = m_ovf;
        s[2]    = (q.size() == 0);
        s[1]    = (q.size() == DEPTH);
        s[0]    = m_active;
        return s;
    endfunction

    task automatic m_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int pre;
        bit pop;
        bit win;
        if (r) begin
            q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
            return;
        end
        pre = q.size();
        pop = 1'b0;
        win = ((a >> 3) == (BASE >> 3));
        if (m_active && m_pos < FL - 1) begin
            m_pos++;
        end else if (pre > 0) begin
            pop      = 1'b1;
            m_byte   = q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end else begin
            m_active = 1'b0;
        end
        if (w && win && !a[2]) begin
            if (pre < DEPTH || pop) q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (w && win && a[2]) m_ovf = 1'b0;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        exp_sel;
        logic [31:0] exp_rd;
        rst = r;
        we = w;
        mem_address = a;
        w_data = d;
        #1;
        exp_sel = ((a >> 3) == (BASE >> 3));
        exp_rd  = (exp_sel && a[2]) ? m_status() : 32'h0;
        s_sel   = sel;
        s_rd    = r_data;
        chk("sel", 32'(sel), 32'(exp_sel));
        chk("r_data", r_data, exp_rd);
        @(posedge clk);
        m_edge(r, w, a, d);
        @(negedge clk);
        chk("tx", 32'(tx), 32'(m_tx()));
        if (cyc_n < LOGN) begin
            tx_log[cyc_n]   = tx;
            busy_log[cyc_n] = s_rd[0];
        end
        cyc_n++;
    endtask

    task automatic rd_stat();
        cyc(1'b0, 1'b0, BASE + 32'h4, 32'h0);
    endtask

    task automatic store(input logic [7:0] b);
        cyc(1'b0, 1'b1, BASE, {24'h0, b});
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 4000 && (m_active || q.size() != 0); n++) rd_stat();
        rd_stat();
        chk("idle_wait", 32'(m_active || q.size() != 0), 32'h0);
    endtask

    task automatic check_frame(input int start, input logic [7:0] b, input string nm);
        for (int i = 0; i < NBITS; i++)
            chk(nm, 32'(tx_log[start + i*C + C/2]), 32'(frame_bit(b, i)));
    endtask

    function automatic int busy_count(input int from, input int to);
        int n;
        n = 0;
        for (int e = from; e <= to; e++) n += int'(busy_log[e]);
        return n;
    endfunction

    initial begin
        int k;
        int r;
        int prob;
        int zeros;
        logic [31:0] d;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(1'b1, 1'b0, BASE + 32'h4, 32'h0);

        tbl[0] = '{1'b0, 32'h0000_F004, 32'h0,  1'b1, 32'h4};
        tbl[1] = '{1'b0, 32'h0000_F000, 32'h0,  1'b1, 32'h0};
        tbl[2] = '{1'b0, 32'h0000_F007, 32'h0,  1'b1, 32'h4};
        tbl[3] = '{1'b0, 32'h0000_F008, 32'h0,  1'b0, 32'h0};
        tbl[4] = '{1'b0, 32'h0000_EFFC, 32'h0,  1'b0, 32'h0};
        tbl[5] = '{1'b1, 32'h0000_F008, 32'h55, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 32'h0001_F000, 32'h66, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 32'h0000_F004, 32'h0,  1'b1, 32'h4};
        tbl[8] = '{1'b0, 32'h0000_F004, 32'h0,  1'b1, 32'h4};
        tbl[9] = '{1'b0, 32'h0000_F003, 32'h0,  1'b1, 32'h0};
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, tbl[i].w, tbl[i].a, tbl[i].d);
            chk("tbl_sel", 32'(s_sel), 32'(tbl[i].e_sel));
            chk("tbl_rdata", s_rd, tbl[i].e_rd);
            chk("tbl_tx_idle", 32'(tx_log[cyc_n-1]), 32'h1);
        end

        // Single A5 frame: start bit one cycle after the push edge.
        k = cyc_n;
        store(8'hA5);
        repeat (FL + 4) rd_stat();
        chk("a5_pre_start", 32'(tx_log[k]), 32'h1);
        chk("a5_start", 32'(tx_log[k+1]), 32'h0);
        check_frame(k + 1, 8'hA5, "a5_bit");
        chk("a5_len", busy_count(k + 1, k + FL + 4), FL);
        chk("a5_status_after", s_rd, 32'h4);

        // Burst of five, overflow on sixth, clear, then push on the STOP->START pop edge.
        wait_idle();
        k = cyc_n;
        for (int b = 1; b <= 5; b++) store(8'(b));
        store(8'hEE);
        rd_stat();
        chk("ovf_set", s_rd, 32'h4B);
        cyc(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        rd_stat();
        chk("ovf_clr", s_rd, 32'h43);
        while (cyc_n < k + 1 + FL) rd_stat();
        store(8'h06);
        rd_stat();
        chk("push_on_pop", s_rd, 32'h43);
        wait_idle();
        for (int f = 0; f < 6; f++)
            check_frame(k + 1 + f*FL, (f < 5) ? 8'(f + 1) : 8'h06, "burst_bit");
        chk("burst_end_idle", 32'(tx_log[k + 1 + 6*FL]), 32'h1);

        // Reset in the middle of DATA with two bytes still queued.
        k = cyc_n;
        store(8'h3C);
        store(8'h11);
        store(8'h22);
        while (cyc_n < k + 1 + 3*C + 1) rd_stat();
        chk("pre_rst_busy", s_rd & 32'h1, 32'h1);
        cyc(1'b1, 1'b0, BASE + 32'h4, 32'h0);
        chk("rst_tx", 32'(tx_log[cyc_n-1]), 32'h1);
        rd_stat();
        chk("rst_status", s_rd, 32'h4);
        k = cyc_n;
        repeat (60) rd_stat();
        zeros = 0;
        for (int e = k; e < cyc_n; e++) if (tx_log[e] == 1'b0) zeros++;
        chk("rst_no_frames", zeros, 0);

`ifdef UART_TX_PARITY_EN
        k = cyc_n;
        store(8'h07);
        repeat (FL + 4) rd_stat();
        chk("par07_bit", 32'(tx_log[k + 1 + 9*C + C/2]), 32'h1);
        chk("par07_len", busy_count(k + 1, k + FL + 4), 44);
        k = cyc_n;
        store(8'h03);
        repeat (FL + 4) rd_stat();
        chk("par03_bit", 32'(tx_log[k + 1 + 9*C + C/2]), 32'h0);
`endif

        // Randomised traffic, alternating heavy and light store phases.
        for (int i = 0; i < 1600; i++) begin
            prob = ((i / 200) % 2 == 0) ? 40 : 4;
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < prob)
                cyc(1'b0, 1'b1, BASE + 32'($urandom_range(0, 3)), d);
            else if (r < prob + 6)
                cyc(1'b0, 1'b1, BASE + 32'h4 + 32'($urandom_range(0, 3)), d);
            else if (r < prob + 10)
                cyc(1'b0, 1'b1, 32'h0002_0000 | 32'($urandom_range(0, 65535)), d);
            else if (r < prob + 11)
                cyc(1'b1, 1'b0, BASE + 32'h4, d);
            else if (r < prob + 25)
                cyc(1'b0, 1'b0, d, 32'h0);
            else
                rd_stat();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
